// File: rtl/neuron_layer_pingpong.sv
// neuron_layer_pingpong: double-buffered neuron layer register.
// Loads (overwrite or saturating accumulate) go to a hidden shadow bank while
// the active bank drives `values`; `commit` publishes the shadow atomically
// and clears it for the next fill.
module neuron_layer_pingpong #(
  parameter int SIZE     = 16,
  parameter int LAYER_SZ = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_en,
  input  logic                            load_acc,
  input  logic [SIZE-1:0]                 load_value,
  input  logic [SIZE-1:0]                 load_address,
  input  logic                            commit,
  output logic [0:LAYER_SZ-1][SIZE-1:0]   values,
  output logic                            values_valid,
  output logic                            shadow_full,
  output logic                            load_err
);

  // Wide enough to hold both the full address and LAYER_SZ without truncation.
  localparam int unsigned AW = (SIZE > 32) ? SIZE : 32;

  typedef logic [0:LAYER_SZ-1][SIZE-1:0] bank_t;

  bank_t                active;
  bank_t                shadow;
  bank_t                shadow_next;
  logic [LAYER_SZ-1:0]  written;
  logic [LAYER_SZ-1:0]  written_next;
  logic [AW-1:0]        addr_ext;
  logic                 in_range;

  // Signed add at SIZE+1 bits; on overflow clamp to the extreme of the sign
  // carried by the extra bit, so wrap-around never reaches storage.
  function automatic logic [SIZE-1:0] sat_add(input logic [SIZE-1:0] a,
                                              input logic [SIZE-1:0] b);
    logic [SIZE:0] s;
    s = {a[SIZE-1], a} + {b[SIZE-1], b};
    if (s[SIZE] != s[SIZE-1])
      return s[SIZE] ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};
    return s[SIZE-1:0];
  endfunction

  assign addr_ext = AW'(load_address);
  assign in_range = addr_ext < AW'(LAYER_SZ);

  // Shadow after applying this cycle's write; also the data a same-cycle
  // commit publishes, so a load in the commit cycle is never lost.
  always_comb begin
    shadow_next  = shadow;
    written_next = written;
    for (int unsigned i = 0; i < LAYER_SZ; i++) begin
      if (load_en && in_range && (addr_ext == AW'(i))) begin
        shadow_next[i]  = load_acc ? sat_add(shadow[i], load_value) : load_value;
        written_next[i] = 1'b1;
      end
    end
  end

  // Bank storage, publish/clear on commit, and the registered error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active       <= '0;
      shadow       <= '0;
      written      <= '0;
      values_valid <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      load_err <= load_en && !in_range;
      if (commit) begin
        active       <= shadow_next;
        shadow       <= '0;
        written      <= '0;
        values_valid <= 1'b1;
      end else begin
        shadow  <= shadow_next;
        written <= written_next;
      end
    end
  end

  assign values      = active;
  assign shadow_full = &written;

endmodule

// File: tb/tb_neuron_layer_pingpong.sv
// Self-checking bench for neuron_layer_pingpong (SIZE=16, LAYER_SZ=2):
// directed scenarios followed by random traffic against an integer model.
module tb_neuron_layer_pingpong;
  localparam int SIZE     = 16;
  localparam int LAYER_SZ = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst_n;
  logic                          load_en;
  logic                          load_acc;
  logic [SIZE-1:0]               load_value;
  logic [SIZE-1:0]               load_address;
  logic                          commit;
  logic [0:LAYER_SZ-1][SIZE-1:0] values;
  logic                          values_valid;
  logic                          shadow_full;
  logic                          load_err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: plain signed integers per neuron.
  int sh_m [LAYER_SZ];
  int ac_m [LAYER_SZ];
  bit wr_m [LAYER_SZ];
  bit valid_m;
  bit err_m;

  neuron_layer_pingpong #(.SIZE(SIZE), .LAYER_SZ(LAYER_SZ)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en      (load_en),
    .load_acc     (load_acc),
    .load_value   (load_value),
    .load_address (load_address),
    .commit       (commit),
    .values       (values),
    .values_valid (values_valid),
    .shadow_full  (shadow_full),
    .load_err     (load_err)
  );

  task automatic model_reset();
    for (int i = 0; i < LAYER_SZ; i++) begin
      sh_m[i] = 0; ac_m[i] = 0; wr_m[i] = 1'b0;
    end
    valid_m = 1'b0;
    err_m   = 1'b0;
  endtask

  task automatic model_clock();
    int a;
    int v;
    int s;
    a = int'(load_address);
    v = int'($signed(load_value));
    err_m = load_en && (a >= LAYER_SZ);
    if (load_en && a < LAYER_SZ) begin
      s = load_acc ? sh_m[a] + v : v;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      sh_m[a] = s;
      wr_m[a] = 1'b1;
    end
    if (commit) begin
      for (int i = 0; i < LAYER_SZ; i++) begin
        ac_m[i] = sh_m[i]; sh_m[i] = 0; wr_m[i] = 1'b0;
      end
      valid_m = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit full;
    full = 1'b1;
    for (int i = 0; i < LAYER_SZ; i++) begin
      chk($sformatf("%s values[%0d]", tag, i), values[i], SIZE'(ac_m[i]));
      full = full & wr_m[i];
    end
    chk({tag, " values_valid"}, SIZE'(values_valid), SIZE'(valid_m));
    chk({tag, " shadow_full"},  SIZE'(shadow_full),  SIZE'(full));
    chk({tag, " load_err"},     SIZE'(load_err),     SIZE'(err_m));
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check 1 after.
  task automatic step(input string tag, input logic en, input logic acc,
                      input logic [SIZE-1:0] val, input logic [SIZE-1:0] addr,
                      input logic cm);
    @(negedge clk);
    load_en = en; load_acc = acc; load_value = val; load_address = addr; commit = cm;
    @(posedge clk);
    model_clock();
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [SIZE-1:0] ra;
    logic [SIZE-1:0] rv;
    rst_n = 1'b0; load_en = 1'b0; load_acc = 1'b0;
    load_value = '0; load_address = '0; commit = 1'b0;
    model_reset();

    // 1: reset then idle
    #12;
    check_all("reset");
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, '0, '0, 1'b0);

    // 2: shadow isolation, then commit
    step("t2_w0", 1'b1, 1'b0, 16'h8000, 16'd0, 1'b0);
    step("t2_w1", 1'b1, 1'b0, 16'h0008, 16'd1, 1'b0);
    chk("t2_full_const", SIZE'(shadow_full), 16'd1);
    step("t2_commit", 1'b0, 1'b0, '0, '0, 1'b1);
    chk("t2_v0_const", values[0], 16'h8000);
    chk("t2_v1_const", values[1], 16'h0008);
    step("t2_after", 1'b0, 1'b0, '0, '0, 1'b0);

    // 3: saturating accumulate
    step("t3_ow1",  1'b1, 1'b0, 16'h7000, 16'd1, 1'b0);
    step("t3_acc1", 1'b1, 1'b1, 16'h2000, 16'd1, 1'b0);
    step("t3_c1",   1'b0, 1'b0, '0, '0, 1'b1);
    chk("t3_pos_sat", values[1], 16'h7FFF);
    step("t3_ow0",  1'b1, 1'b0, 16'h9000, 16'd0, 1'b0);
    step("t3_acc0", 1'b1, 1'b1, 16'hE000, 16'd0, 1'b0);
    step("t3_c2",   1'b0, 1'b0, '0, '0, 1'b1);
    chk("t3_neg_sat", values[0], 16'h8000);
    step("t3_a1",   1'b1, 1'b1, 16'h0100, 16'd0, 1'b0);
    step("t3_a2",   1'b1, 1'b1, 16'h0100, 16'd0, 1'b0);
    step("t3_c3",   1'b0, 1'b0, '0, '0, 1'b1);
    chk("t3_chain", values[0], 16'h0200);

    // 4: same-cycle load + commit, then back-to-back commit
    step("t4_w0", 1'b1, 1'b0, 16'h8000, 16'd0, 1'b0);
    step("t4_w1", 1'b1, 1'b0, 16'h0008, 16'd1, 1'b0);
    step("t4_c0", 1'b0, 1'b0, '0, '0, 1'b1);
    step("t4_lc", 1'b1, 1'b0, 16'h1111, 16'd1, 1'b1);
    chk("t4_lc_v0", values[0], 16'h0000);
    chk("t4_lc_v1", values[1], 16'h1111);
    step("t4_c2", 1'b0, 1'b0, '0, '0, 1'b1);
    chk("t4_c2_v1", values[1], 16'h0000);

    // 5: out-of-range writes leave storage alone
    step("t5_w0",   1'b1, 1'b0, 16'h0042, 16'd0,    1'b0);
    step("t5_oor2", 1'b1, 1'b0, 16'h1234, 16'd2,    1'b0);
    step("t5_oorF", 1'b1, 1'b0, 16'h1234, 16'hFFFF, 1'b0);
    chk("t5_err_const", SIZE'(load_err), 16'd1);
    step("t5_c",    1'b0, 1'b0, '0, '0, 1'b1);
    chk("t5_v0", values[0], 16'h0042);
    chk("t5_v1", values[1], 16'h0000);
    chk("t5_err_drop", SIZE'(load_err), 16'd0);

    // 6: async reset mid-fill
    step("t6_w0", 1'b1, 1'b0, 16'h5555, 16'd0, 1'b0);
    step("t6_c",  1'b1, 1'b0, 16'h3333, 16'd1, 1'b1);
    @(negedge clk); load_en = 1'b0; commit = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("t6_async");
    chk("t6_v1_zero", values[1], 16'h0000);
    #1 rst_n = 1'b1;
    step("t6_commit", 1'b0, 1'b0, '0, '0, 1'b1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: ra = 16'd0;
        1: ra = 16'd1;
        2: ra = 16'd2;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: rv = 16'h7FFF;
        1: rv = 16'h8000;
        default: rv = 16'($urandom);
      endcase
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), rv, ra,
           1'($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
